// File: rtl/game_pkg.sv
// Game-state bus encodings and digit code width shared by the countdown, sprite
// and pause/resume blocks.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETTING   = 3'd1,
      SYNCING   = 3'd2,
      COUNTDOWN = 3'd3,
      RACING    = 3'd4,
      PAUSE     = 3'd5,
      FINISH    = 3'd6
   } game_state_e;

   localparam int NUM_W = 2;

endpackage

// File: rtl/countdown_sequencer_tick_timer.sv
// Interval counter with synchronous clear and a programmable terminal value;
// term is high on the enabled cycle where the count equals tc, and the count wraps to 0.
module tick_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] tc,
   output logic         term
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      term  = en && (cnt_q == tc);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = term ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/countdown_sequencer.sv
// Pre-race countdown: shows START_NUM..1 for TICKS_PER_SEC cycles each, beeps per digit, pulses done.
// Define COUNTDOWN_GO_EN to insert a GO phase of GO_TICKS cycles between digit 1 and done.
module countdown_sequencer
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int START_NUM     = 3,
   parameter int GO_TICKS      = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       state,
   output logic [NUM_W-1:0] num,
   output logic             countdown_done,
   output logic             beep,
   output logic             go_active
);

   localparam int MAX_TICKS = (TICKS_PER_SEC > GO_TICKS) ? TICKS_PER_SEC : GO_TICKS;
   localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [CW-1:0]    SEC_TC    = CW'(TICKS_PER_SEC - 1);
   localparam logic [NUM_W-1:0] START_VAL = NUM_W'(START_NUM);

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_COUNT = 2'd1,
      S_HOLD  = 2'd2
`ifdef COUNTDOWN_GO_EN
      , S_GO  = 2'd3
`endif
   } seq_e;

   seq_e             seq_q, seq_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic             beep_q, beep_d;
   logic             done_q, done_d;
   logic [2:0]       prev_state_q, prev_state_d;

   logic            in_cd;
   logic            tmr_clr, tmr_en, tmr_term;
   logic [CW-1:0]   tmr_tc;

`ifdef COUNTDOWN_GO_EN
   localparam logic [CW-1:0] GO_TC = CW'(GO_TICKS - 1);
   logic go_q, go_d;
   assign go_active = go_q;
`else
   assign go_active = 1'b0;
`endif

   tick_timer #(.W(CW)) u_tick_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .en   (tmr_en),
      .tc   (tmr_tc),
      .term (tmr_term)
   );

   always_comb begin
      seq_d        = seq_q;
      num_d        = num_q;
      beep_d       = 1'b0;
      done_d       = 1'b0;
      prev_state_d = state;
      tmr_clr      = 1'b0;
      tmr_en       = 1'b0;
      tmr_tc       = SEC_TC;
`ifdef COUNTDOWN_GO_EN
      go_d         = go_q;
`endif
      in_cd        = (state == COUNTDOWN);

      case (seq_q)
         S_WAIT: begin
            num_d = '0;
            // Edge-triggered entry so a lingering COUNTDOWN never retriggers.
            if (in_cd && (prev_state_q != COUNTDOWN)) begin
               num_d   = START_VAL;
               beep_d  = 1'b1;
               tmr_clr = 1'b1;
               seq_d   = S_COUNT;
            end
         end
         S_COUNT: begin
            // Leaving COUNTDOWN (PAUSE included) aborts, even on the final tick.
            if (!in_cd) begin
               num_d   = '0;
               tmr_clr = 1'b1;
               seq_d   = S_WAIT;
            end else begin
               tmr_en = 1'b1;
               if (tmr_term) begin
                  if (num_q > NUM_W'(1)) begin
                     num_d  = num_q - NUM_W'(1);
                     beep_d = 1'b1;
                  end else begin
                     num_d = '0;
`ifdef COUNTDOWN_GO_EN
                     go_d   = 1'b1;
                     beep_d = 1'b1;
                     seq_d  = S_GO;
`else
                     done_d = 1'b1;
                     seq_d  = S_HOLD;
`endif
                  end
               end
            end
         end
`ifdef COUNTDOWN_GO_EN
         S_GO: begin
            num_d = '0;
            if (!in_cd) begin
               go_d    = 1'b0;
               tmr_clr = 1'b1;
               seq_d   = S_WAIT;
            end else begin
               tmr_en = 1'b1;
               tmr_tc = GO_TC;
               if (tmr_term) begin
                  go_d   = 1'b0;
                  done_d = 1'b1;
                  seq_d  = S_HOLD;
               end
            end
         end
`endif
         S_HOLD: begin
            num_d = '0;
            if (!in_cd) begin
               seq_d = S_WAIT;
            end
         end
         default: begin
            num_d = '0;
            seq_d = S_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q        <= S_WAIT;
         num_q        <= '0;
         beep_q       <= 1'b0;
         done_q       <= 1'b0;
         prev_state_q <= IDLE;
`ifdef COUNTDOWN_GO_EN
         go_q         <= 1'b0;
`endif
      end else begin
         seq_q        <= seq_d;
         num_q        <= num_d;
         beep_q       <= beep_d;
         done_q       <= done_d;
         prev_state_q <= prev_state_d;
`ifdef COUNTDOWN_GO_EN
         go_q         <= go_d;
`endif
      end
   end

   assign num            = num_q;
   assign beep           = beep_q;
   assign countdown_done = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: timeline reference model driven by scripted and random game-state traces.
module tb_countdown_sequencer;
   import game_pkg::*;

   localparam int T  = 10;
   localparam int SN = 3;
   localparam int G  = 5;
`ifdef COUNTDOWN_GO_EN
   localparam bit GO = 1'b1;
`else
   localparam bit GO = 1'b0;
`endif
   localparam int RUN_LEN = SN * T + (GO ? G : 0);

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic [1:0] num;
   logic       countdown_done, beep, go_active;

   int n_checks = 0;
   int n_err    = 0;

   // reference model: countdown described as time elapsed since the start edge
   int         m_cyc = 0;
   int         m_start = 0;
   bit         m_run = 0, m_hold = 0;
   logic [2:0] m_prev = IDLE;
   logic [1:0] exp_num = 0;
   logic       exp_done = 0, exp_beep = 0, exp_go = 0;

   countdown_sequencer #(
      .TICKS_PER_SEC (T),
      .START_NUM     (SN),
      .GO_TICKS      (G)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .state          (state),
      .num            (num),
      .countdown_done (countdown_done),
      .beep           (beep),
      .go_active      (go_active)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] obs();
      return {num, countdown_done, beep, go_active};
   endfunction

   function automatic logic [4:0] exp_vec();
      return {exp_num, exp_done, exp_beep, exp_go};
   endfunction

   task automatic model_reset();
      m_run = 0; m_hold = 0; m_prev = IDLE;
      exp_num = 0; exp_done = 0; exp_beep = 0; exp_go = 0;
   endtask

   task automatic model_edge(input logic [2:0] st);
      int el;
      m_cyc++;
      exp_beep = 0;
      exp_done = 0;
      if (m_run) begin
         el = m_cyc - m_start;
         if (st != COUNTDOWN) begin
            m_run = 0; exp_num = 0; exp_go = 0;
         end else if (el < SN * T) begin
            exp_num  = 2'(SN - el / T);
            exp_beep = (el % T == 0);
         end else if (GO && el < SN * T + G) begin
            exp_num  = 0;
            exp_go   = 1;
            exp_beep = (el == SN * T);
         end else begin
            exp_num = 0; exp_go = 0; exp_done = 1;
            m_run = 0; m_hold = 1;
         end
      end else if (m_hold) begin
         if (st != COUNTDOWN) m_hold = 0;
      end else if (st == COUNTDOWN && m_prev != COUNTDOWN) begin
         m_run = 1; m_start = m_cyc;
         exp_num = 2'(SN); exp_beep = 1;
      end
      m_prev = st;
   endtask

   task automatic drive(input logic [2:0] st);
      state = st;
      @(posedge clk);
      model_edge(st);
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_err++;
         $display("FAIL reset_state got=%b want=%b", obs(), 5'b0);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         drive(IDLE);
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_idle cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_basic();
      int entry = 0, done_at = -1, beeps = 0, dones = 0;
      for (int i = 0; i < 5; i++) drive(IDLE);
      for (int i = 0; i < RUN_LEN + 10; i++) begin
         drive(COUNTDOWN);
         if (i == 0) begin
            entry = m_cyc;
            n_checks++;
            if (num !== 2'(SN)) begin
               n_err++;
               $display("FAIL basic_first_digit got=%0d want=%0d", num, SN);
            end
         end
         if (beep === 1'b1) beeps++;
         if (countdown_done === 1'b1) begin dones++; done_at = m_cyc; end
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL basic cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
      end
      n_checks++;
      if (dones != 1) begin
         n_err++;
         $display("FAIL basic_done_count got=%0d want=1", dones);
      end
      n_checks++;
      if (beeps != SN + (GO ? 1 : 0)) begin
         n_err++;
         $display("FAIL basic_beep_count got=%0d want=%0d", beeps, SN + (GO ? 1 : 0));
      end
      n_checks++;
      if (done_at - entry != RUN_LEN) begin
         n_err++;
         $display("FAIL basic_done_latency got=%0d want=%0d", done_at - entry, RUN_LEN);
      end
   endtask

   task automatic test_hold_restart();
      int nonzero = 0;
      for (int i = 0; i < 100; i++) begin
         drive(COUNTDOWN);
         if (num !== 2'd0 || beep !== 1'b0 || countdown_done !== 1'b0) nonzero++;
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL hold cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
      end
      n_checks++;
      if (nonzero != 0) begin
         n_err++;
         $display("FAIL hold_no_restart active_cycles got=%0d want=0", nonzero);
      end
      drive(RACING);
      for (int i = 0; i < RUN_LEN + 5; i++) begin
         drive(COUNTDOWN);
         if (i == 0) begin
            n_checks++;
            if (num !== 2'(SN)) begin
               n_err++;
               $display("FAIL rerace_first_digit got=%0d want=%0d", num, SN);
            end
         end
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL rerace cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_pause_abort();
      drive(IDLE);
      for (int i = 0; i < T + 3; i++) drive(COUNTDOWN);
      n_checks++;
      if (num !== 2'(SN - 1)) begin
         n_err++;
         $display("FAIL pause_pre_digit got=%0d want=%0d", num, SN - 1);
      end
      drive(PAUSE);
      n_checks++;
      if (num !== 2'd0 || countdown_done !== 1'b0) begin
         n_err++;
         $display("FAIL pause_abort num=%0d done=%b want num=0 done=0", num, countdown_done);
      end
      for (int i = 0; i < 3; i++) drive(PAUSE);
      for (int i = 0; i < RUN_LEN + 5; i++) begin
         drive(COUNTDOWN);
         if (i == 0) begin
            n_checks++;
            if (num !== 2'(SN)) begin
               n_err++;
               $display("FAIL pause_resume_digit got=%0d want=%0d", num, SN);
            end
         end
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL pause cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_abort_final();
      int dones = 0;
      drive(IDLE);
      drive(IDLE);
      for (int i = 0; i < SN * T; i++) drive(COUNTDOWN);
      // this edge would otherwise expire digit 1
      drive(RACING);
      for (int i = 0; i < 12; i++) begin
         if (countdown_done === 1'b1) dones++;
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL abort_final cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
         drive(RACING);
      end
      n_checks++;
      if (dones != 0) begin
         n_err++;
         $display("FAIL abort_final_done got=%0d want=0", dones);
      end
   endtask

   task automatic test_rst_mid();
      drive(IDLE);
      for (int i = 0; i < T + 3; i++) drive(COUNTDOWN);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 5'b0) begin
         n_err++;
         $display("FAIL rst_async got=%b want=%b", obs(), 5'b0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < RUN_LEN + 5; i++) begin
         drive(COUNTDOWN);
         if (i == 0) begin
            n_checks++;
            if (num !== 2'(SN)) begin
               n_err++;
               $display("FAIL rst_restart_digit got=%0d want=%0d", num, SN);
            end
         end
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL rst_restart cyc=%0d got=%b want=%b", m_cyc, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int         left = 0;
      logic [2:0] st = IDLE;
      for (int i = 0; i < 3000; i++) begin
         if (left == 0) begin
            if ($urandom_range(0, 9) < 6) begin
               st   = COUNTDOWN;
               left = $urandom_range(1, 60);
            end else begin
               st   = 3'($urandom_range(0, 6));
               left = $urandom_range(1, 4);
            end
         end
         left--;
         drive(st);
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL random cyc=%0d st=%0d got=%b want=%b", m_cyc, st, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      state = IDLE;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_hold_restart();
      test_pause_abort();
      test_abort_final();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
